// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 Hz timing constants, derived totals and sync windows,
// plus the coordinate type and window-decode helper shared by the VGA block.
package vga_timing_pkg;

    typedef logic [9:0] coord_t;

    localparam int unsigned DEF_H_DISPLAY = 640;
    localparam int unsigned DEF_H_FRONT   = 16;
    localparam int unsigned DEF_H_SYNC    = 96;
    localparam int unsigned DEF_H_BACK    = 48;
    localparam int unsigned DEF_V_DISPLAY = 480;
    localparam int unsigned DEF_V_FRONT   = 10;
    localparam int unsigned DEF_V_SYNC    = 2;
    localparam int unsigned DEF_V_BACK    = 33;

    localparam int unsigned DEF_H_TOTAL =
        DEF_H_DISPLAY + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int unsigned DEF_V_TOTAL =
        DEF_V_DISPLAY + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    localparam int unsigned DEF_HS_START = DEF_H_DISPLAY + DEF_H_FRONT;
    localparam int unsigned DEF_HS_END   = DEF_HS_START + DEF_H_SYNC - 1;
    localparam int unsigned DEF_VS_START = DEF_V_DISPLAY + DEF_V_FRONT;
    localparam int unsigned DEF_VS_END   = DEF_VS_START + DEF_V_SYNC - 1;

    // True when v lies in the inclusive window lo..hi.
    function automatic logic in_window(coord_t v, coord_t lo, coord_t hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/pixel_tick_div.sv
// Divides clk down to a one-cycle pixel strobe every CLK_DIV cycles.
// With CLK_DIV==1 the counter never leaves zero, so the strobe is constant 1.
module pixel_tick_div #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic p_tick_o
);

    localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_cnt_q;
    logic [DW-1:0] div_cnt_d;

    // Next divider count: wrap to zero after the last phase.
    always_comb begin
        div_cnt_d = (div_cnt_q == LAST) ? '0 : div_cnt_q + 1'b1;
    end

    // Divider register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) div_cnt_q <= '0;
        else       div_cnt_q <= div_cnt_d;
    end

    assign p_tick_o = (div_cnt_q == LAST);

endmodule

// File: rtl/vga_sync.sv
// VGA timing generator: pixel coordinates, registered sync/video outputs
// and pixel/line/frame strobes.
module vga_sync
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_DISPLAY   = DEF_H_DISPLAY,
    parameter int unsigned H_FRONT     = DEF_H_FRONT,
    parameter int unsigned H_SYNC      = DEF_H_SYNC,
    parameter int unsigned H_BACK      = DEF_H_BACK,
    parameter int unsigned V_DISPLAY   = DEF_V_DISPLAY,
    parameter int unsigned V_FRONT     = DEF_V_FRONT,
    parameter int unsigned V_SYNC      = DEF_V_SYNC,
    parameter int unsigned V_BACK      = DEF_V_BACK,
    parameter int unsigned CLK_DIV     = 4,
    parameter logic        SYNC_ACTIVE = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       p_tick,
    output logic       line_tick,
    output logic       frame_tick,
    output logic [9:0] x,
    output logic [9:0] y
);

    localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
    localparam coord_t H_VIS    = coord_t'(H_DISPLAY);
    localparam coord_t V_VIS    = coord_t'(V_DISPLAY);
    localparam coord_t HS_START = coord_t'(H_DISPLAY + H_FRONT);
    localparam coord_t HS_END   = coord_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam coord_t VS_START = coord_t'(V_DISPLAY + V_FRONT);
    localparam coord_t VS_END   = coord_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic   p_tick_w;
    logic   x_wrap;
    coord_t x_q, x_d;
    coord_t y_q, y_d;
    logic   hsync_q, hsync_d;
    logic   vsync_q, vsync_d;
    logic   video_on_q, video_on_d;

    pixel_tick_div #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .p_tick_o (p_tick_w)
    );

    assign x_wrap = p_tick_w && (x_q == H_LAST);

    // Next-state counters and the outputs decoded from them, so the
    // registered sync/video flags line up with x/y on the same edge.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (p_tick_w) begin
            x_d = (x_q == H_LAST) ? '0 : x_q + 10'd1;
            if (x_wrap) begin
                y_d = (y_q == V_LAST) ? '0 : y_q + 10'd1;
            end
        end
        hsync_d    = in_window(x_d, HS_START, HS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vsync_d    = in_window(y_d, VS_START, VS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        video_on_d = (x_d < H_VIS) && (y_d < V_VIS);
    end

    // Coordinate and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q        <= '0;
            y_q        <= '0;
            hsync_q    <= ~SYNC_ACTIVE;
            vsync_q    <= ~SYNC_ACTIVE;
            video_on_q <= 1'b1;
        end else begin
            x_q        <= x_d;
            y_q        <= y_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            video_on_q <= video_on_d;
        end
    end

    assign x          = x_q;
    assign y          = y_q;
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign video_on   = video_on_q;
    assign p_tick     = p_tick_w;
    assign line_tick  = x_wrap;
    assign frame_tick = x_wrap && (y_q == V_LAST);

endmodule

// File: tb/tb_vga_sync.sv
module tb_vga_sync;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       von;
        logic       pt;
        logic       lt;
        logic       ft;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    // Reduced-timing instance: frame is 4*30*17 = 2040 clks.
    logic       s_hs, s_vs, s_von, s_pt, s_lt, s_ft;
    logic [9:0] s_x, s_y;
    // Default 640x480 instance.
    logic       d_hs, d_vs, d_von, d_pt, d_lt, d_ft;
    logic [9:0] d_x, d_y;

    int n_tests = 0;
    int n_fail  = 0;
    int k       = 0;   // clk edges since reset release

    vga_sync #(
        .H_DISPLAY (16), .H_FRONT (4), .H_SYNC (6), .H_BACK (4),
        .V_DISPLAY (10), .V_FRONT (2), .V_SYNC (2), .V_BACK (3),
        .CLK_DIV (4), .SYNC_ACTIVE (1'b0)
    ) u_small (
        .clk (clk), .reset (reset), .hsync (s_hs), .vsync (s_vs),
        .video_on (s_von), .p_tick (s_pt), .line_tick (s_lt),
        .frame_tick (s_ft), .x (s_x), .y (s_y)
    );

    vga_sync u_def (
        .clk (clk), .reset (reset), .hsync (d_hs), .vsync (d_vs),
        .video_on (d_von), .p_tick (d_pt), .line_tick (d_lt),
        .frame_tick (d_ft), .x (d_x), .y (d_y)
    );

    always #5 clk = ~clk;

    // Timing from first principles: pixel index = elapsed clks / div.
    function automatic exp_t model(int kk, int div, int hd, int hf, int hs, int hb,
                                   int vd, int vf, int vs, int vb);
        exp_t e;
        int ht, vt, p, xx, yy;
        ht = hd + hf + hs + hb;
        vt = vd + vf + vs + vb;
        p  = kk / div;
        xx = p % ht;
        yy = (p / ht) % vt;
        e.x   = 10'(xx);
        e.y   = 10'(yy);
        e.hs  = !((xx >= hd + hf) && (xx < hd + hf + hs));
        e.vs  = !((yy >= vd + vf) && (yy < vd + vf + vs));
        e.von = (xx < hd) && (yy < vd);
        e.pt  = (kk % div) == div - 1;
        e.lt  = e.pt && (xx == ht - 1);
        e.ft  = e.lt && (yy == vt - 1);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s k=%0d observed=%0d expected=%0d", tag, k, obs, exp);
        end
    endtask

    task automatic check_all();
        exp_t es, ed;
        es = model(k, 4, 16, 4, 6, 4, 10, 2, 2, 3);
        ed = model(k, 4, 640, 16, 96, 48, 480, 10, 2, 33);
        chk("s_x", s_x, es.x);           chk("s_y", s_y, es.y);
        chk("s_hsync", 10'(s_hs), 10'(es.hs));
        chk("s_vsync", 10'(s_vs), 10'(es.vs));
        chk("s_video_on", 10'(s_von), 10'(es.von));
        chk("s_p_tick", 10'(s_pt), 10'(es.pt));
        chk("s_line_tick", 10'(s_lt), 10'(es.lt));
        chk("s_frame_tick", 10'(s_ft), 10'(es.ft));
        chk("d_x", d_x, ed.x);           chk("d_y", d_y, ed.y);
        chk("d_hsync", 10'(d_hs), 10'(ed.hs));
        chk("d_vsync", 10'(d_vs), 10'(ed.vs));
        chk("d_video_on", 10'(d_von), 10'(ed.von));
        chk("d_p_tick", 10'(d_pt), 10'(ed.pt));
        chk("d_line_tick", 10'(d_lt), 10'(ed.lt));
        chk("d_frame_tick", 10'(d_ft), 10'(ed.ft));
    endtask

    // Advance one clk and check at the following falling edge.
    task automatic step();
        @(posedge clk);
        k++;
        @(negedge clk);
        check_all();
    endtask

    // Assert reset asynchronously mid low-phase, check at once, release next negedge.
    task automatic async_reset();
        #2 reset = 1'b1;
        #1 k = 0;
        check_all();
        @(negedge clk);
        check_all();
        reset = 1'b0;
    endtask

    initial begin
        int s_lines, s_frames, s_blank, s_blank_von, s_hlow, s_vlow;
        int d_lines, d_hlow, d_maxx, d_y1_seen;
        int run;

        s_lines = 0; s_frames = 0; s_blank = 0; s_blank_von = 0;
        s_hlow = 0; s_vlow = 0; d_lines = 0; d_hlow = 0; d_maxx = 0; d_y1_seen = 0;

        // Reset values while held in reset.
        repeat (3) @(negedge clk);
        k = 0;
        check_all();
        reset = 1'b0;

        // Free-run: one full small frame and one full default line, plus wrap.
        for (int i = 0; i < 3300; i++) begin
            step();
            if (k <= 2040) begin
                s_lines  += int'(s_lt);
                s_frames += int'(s_ft);
                s_hlow   += int'(!s_hs);
                s_vlow   += int'(!s_vs);
                if (s_x == 10'd0 && s_y == 10'd11) begin
                    s_blank++;
                    s_blank_von += int'(s_von);
                end
            end
            if (k <= 3200) begin
                d_lines += int'(d_lt);
                d_hlow  += int'(!d_hs);
                if (int'(d_x) > d_maxx) d_maxx = int'(d_x);
            end
            if (k == 3201 && d_y == 10'd1 && d_x == 10'd0) d_y1_seen = 1;
        end
        chk("s_line_ticks_per_frame", 10'(s_lines), 10'd17);
        chk("s_frame_ticks_per_frame", 10'(s_frames), 10'd1);
        chk("s_hsync_low_clks", 10'(s_hlow), 10'd408);
        chk("s_vsync_low_clks", 10'(s_vlow), 10'd240);
        chk("s_blank_pair_clks", 10'(s_blank), 10'd4);
        chk("s_blank_pair_video_on", 10'(s_blank_von), 10'd0);
        chk("d_line_ticks_per_line", 10'(d_lines), 10'd1);
        chk("d_hsync_low_clks", 10'(d_hlow), 10'd384);
        chk("d_max_x", 10'(d_maxx), 10'd799);
        chk("d_wrap_to_y1", 10'(d_y1_seen), 10'd1);

        // Reset while both small-instance syncs are active (x=22, y=13).
        async_reset();
        for (int i = 0; i < 4 * (13 * 30 + 22) + 2; i++) step();
        chk("pre_reset_hsync_active", 10'(s_hs), 10'd0);
        chk("pre_reset_vsync_active", 10'(s_vs), 10'd0);
        async_reset();
        for (int i = 0; i < 200; i++) step();

        // Randomly placed mid-frame resets.
        for (int r = 0; r < 4; r++) begin
            run = int'($urandom_range(1, 2300));
            for (int i = 0; i < run; i++) step();
            async_reset();
            for (int i = 0; i < 40; i++) step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
